commit_tracker: RTL and testbench

COMMIT_TRACKER -- requirements
Module: commit_tracker

---
 rtl/commit_tracker.sv | 67 ++++++
 tb/tb_commit_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_tracker.sv
// rtl/commit_tracker.sv - retirement tracker shadowing ID/EX/MEM/WB with retire and cycle counters
// WB slot feeds the debug stage directly from registers; invalid slots always carry pc=0.
module commit_tracker #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fetch_vld,
  input  logic [31:0]      i_if_pc,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_insn_vld,
  output logic [31:0]      o_pc,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  logic        id_vld, ex_vld, mem_vld, wb_vld;
  logic [31:0] id_pc, ex_pc, mem_pc, wb_pc;
  logic [CNT_W-1:0] retire_cnt, cycle_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      id_vld     <= 1'b0;
      id_pc      <= 32'h0;
      ex_vld     <= 1'b0;
      ex_pc      <= 32'h0;
      mem_vld    <= 1'b0;
      mem_pc     <= 32'h0;
      wb_vld     <= 1'b0;
      wb_pc      <= 32'h0;
      retire_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      // Flush outranks stall: the branch already in EX retires, the younger ID/IF work dies.
      if (i_flush) begin
        id_vld <= 1'b0;
        id_pc  <= 32'h0;
      end else if (!i_stall) begin
        id_vld <= i_fetch_vld;
        id_pc  <= i_fetch_vld ? i_if_pc : 32'h0;
      end

      if (i_flush || i_stall) begin
        ex_vld <= 1'b0;
        ex_pc  <= 32'h0;
      end else begin
        ex_vld <= id_vld;
        ex_pc  <= id_pc;
      end

      mem_vld <= ex_vld;
      mem_pc  <= ex_pc;
      wb_vld  <= mem_vld;
      wb_pc   <= mem_pc;

      if (wb_vld) retire_cnt <= retire_cnt + CNT_W'(1);
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign o_insn_vld   = wb_vld;
  assign o_pc         = wb_pc;
  assign o_retire_cnt = retire_cnt;
  assign o_cycle_cnt  = cycle_cnt;

endmodule

// File: tb/tb_commit_tracker.sv
// tb/tb_commit_tracker.sv - scoreboard bench for commit_tracker
// Stimulus pushes {pc, edge-since-reset} it expects in WB; a negedge monitor pops and compares.
module tb_commit_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_vld;
  logic [31:0] if_pc;
  logic        stall;
  logic        flush;
  logic        insn_vld;
  logic [31:0] pc;
  logic [3:0]  retire_cnt;
  logic [3:0]  cycle_cnt;

  typedef struct {
    logic [31:0] pc;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges;

  commit_tracker #(.CNT_W(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fetch_vld  (fetch_vld),
    .i_if_pc      (if_pc),
    .i_stall      (stall),
    .i_flush      (flush),
    .o_insn_vld   (insn_vld),
    .o_pc         (pc),
    .o_retire_cnt (retire_cnt),
    .o_cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (insn_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got pc 0x%0h at edge %0d expected no retirement", pc, edges);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_pc", pc, e.pc);
          chk("wb_edge", edges, e.at);
        end
      end else begin
        chk("bubble_pc", pc, 32'h0);
      end
    end
  end

  task automatic expect_wb(input logic [31:0] p, input int at);
    exp_t e;
    e.pc = p;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic step(input logic fv, input logic [31:0] p, input logic st, input logic fl);
    fetch_vld = fv;
    if_pc     = p;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_vld"}, insn_vld, 1'b0);
    chk({name, "_pc"}, pc, 32'h0);
    chk({name, "_retire"}, retire_cnt, 4'd0);
    chk({name, "_cycle"}, cycle_cnt, 4'd0);
  endtask

  task automatic drain(input string name);
    chk(name, sb.size(), 0);
  endtask

  // Leaves reset released 1 time unit after an edge, so the next edge is edge 1.
  task automatic do_reset;
    fetch_vld = 1'b0;
    if_pc     = 32'h0;
    stall     = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Straight-line: 4-stage latency, first retirement on edge 4.
    step(1'b1, 32'h0, 1'b0, 1'b0); expect_wb(32'h0, 4);
    step(1'b1, 32'h4, 1'b0, 1'b0); expect_wb(32'h4, 5);
    step(1'b1, 32'h8, 1'b0, 1'b0); expect_wb(32'h8, 6);
    step(1'b1, 32'hC, 1'b0, 1'b0); expect_wb(32'hC, 7);
    chk("line_retire_e4", retire_cnt, 4'd0);
    idle(3);
    chk("line_retire_e7", retire_cnt, 4'd3);
    idle(1);
    chk("line_retire_e8", retire_cnt, 4'd4);
    chk("line_cycle_e8", cycle_cnt, 4'd8);
    drain("line_sb_empty");

    // Load-use stall with 0x8 in ID: WB shows 0x4, bubble, 0x8.
    do_reset();
    step(1'b1, 32'h0, 1'b0, 1'b0); expect_wb(32'h0, 4);
    step(1'b1, 32'h4, 1'b0, 1'b0); expect_wb(32'h4, 5);
    step(1'b1, 32'h8, 1'b0, 1'b0); expect_wb(32'h8, 7);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0); expect_wb(32'hC, 8);
    idle(1);
    chk("stall_bubble_vld", insn_vld, 1'b0);
    chk("stall_bubble_pc", pc, 32'h0);
    chk("stall_retire_e6", retire_cnt, 4'd2);
    idle(1);
    chk("stall_retire_e7", retire_cnt, 4'd2);
    idle(2);
    chk("stall_retire_e9", retire_cnt, 4'd4);
    drain("stall_sb_empty");

    // Flush with branch 0xC in EX, 0x10 in ID, 0x14 in IF.
    do_reset();
    step(1'b1, 32'hC,  1'b0, 1'b0); expect_wb(32'hC, 4);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b0, 1'b1);
    step(1'b1, 32'h40, 1'b0, 1'b0); expect_wb(32'h40, 7);
    idle(4);
    chk("flush_retire_e8", retire_cnt, 4'd2);
    drain("flush_sb_empty");

    // Flush and stall together: held ID 0x28 dies, branch 0x24 retires.
    do_reset();
    step(1'b1, 32'h20, 1'b0, 1'b0); expect_wb(32'h20, 4);
    step(1'b1, 32'h24, 1'b0, 1'b0); expect_wb(32'h24, 5);
    step(1'b1, 32'h28, 1'b0, 1'b0);
    step(1'b1, 32'h2C, 1'b1, 1'b1);
    step(1'b1, 32'h50, 1'b0, 1'b0); expect_wb(32'h50, 8);
    idle(4);
    chk("fs_retire_e9", retire_cnt, 4'd3);
    drain("fs_sb_empty");

    // Reset mid-run with 0x60 in WB and three more in flight.
    do_reset();
    step(1'b1, 32'h60, 1'b0, 1'b0); expect_wb(32'h60, 4);
    step(1'b1, 32'h64, 1'b0, 1'b0);
    step(1'b1, 32'h68, 1'b0, 1'b0);
    step(1'b1, 32'h6C, 1'b0, 1'b0);
    #5;
    fetch_vld = 1'b0;
    rst       = 1'b1;
    #1;
    chk_zero("midrst_async");
    drain("midrst_sb_empty");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("midrst_hold");
    rst = 1'b0;
    step(1'b1, 32'h100, 1'b0, 1'b0); expect_wb(32'h100, 4);
    idle(4);
    chk("midrst_retire_e5", retire_cnt, 4'd1);
    drain("midrst_sb_empty2");

    // 17 retirements on a 4-bit counter wrap to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      expect_wb(32'h200 + 32'(4 * i), i + 4);
    end
    idle(3);
    chk("wrap_retire_e20", retire_cnt, 4'd0);
    idle(1);
    chk("wrap_retire_e21", retire_cnt, 4'd1);
    chk("wrap_cycle_e21", cycle_cnt, 4'd5);
    drain("wrap_sb_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
